// File: rtl/two_phase_clkgen.sv
// Non-overlapping two-phase clock generator (ph1/ph1b/ph2/ph2b) run from one system clock.
// Optional single-step feature: define CLKGEN_SINGLE_STEP_EN to add step_mode/step ports.
module two_phase_clkgen #(
    parameter int PH1_CYC = 2,
    parameter int PH2_CYC = 2,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
`ifdef CLKGEN_SINGLE_STEP_EN
    input  logic step_mode,
    input  logic step,
`endif
    output logic ph1,
    output logic ph1b,
    output logic ph2,
    output logic ph2b,
    output logic cycle_start,
    output logic running
);

    localparam int MAX_CYC = (PH1_CYC > PH2_CYC)
                           ? ((PH1_CYC > GAP_CYC) ? PH1_CYC : GAP_CYC)
                           : ((PH2_CYC > GAP_CYC) ? PH2_CYC : GAP_CYC);

    if (PH1_CYC < 1 || PH2_CYC < 1 || GAP_CYC < 1) begin : g_bad_count
        $error("two_phase_clkgen: PH1_CYC, PH2_CYC and GAP_CYC must all be >= 1");
    end
    if (CNT_W < 1 || CNT_W > 31 || (longint'(MAX_CYC) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("two_phase_clkgen: CNT_W cannot hold max(PH1_CYC,PH2_CYC,GAP_CYC)-1");
    end

    localparam logic [CNT_W-1:0] PH1_LD = CNT_W'(PH1_CYC - 1);
    localparam logic [CNT_W-1:0] PH2_LD = CNT_W'(PH2_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_GAP1 = 3'd2,
        S_PH2  = 3'd3,
        S_GAP2 = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ph1_q, ph1b_q, ph2_q, ph2b_q;
    logic             cs_q, run_q;
    logic             cnt_zero;
    logic             start_idle_d;
    logic             start_again_d;

    assign cnt_zero = (cnt_q == '0);

`ifdef CLKGEN_SINGLE_STEP_EN
    logic step_q;
    logic single_q;
    logic step_rise;

    assign step_rise     = step & ~step_q;
    assign start_idle_d  = step_mode ? step_rise : en;
    // A stepped cycle always drops back to IDLE, regardless of en.
    assign start_again_d = en & ~single_q;
`else
    assign start_idle_d  = en;
    assign start_again_d = en;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ph1_q    <= 1'b0;
            ph1b_q   <= 1'b1;
            ph2_q    <= 1'b0;
            ph2b_q   <= 1'b1;
            cs_q     <= 1'b0;
            run_q    <= 1'b0;
`ifdef CLKGEN_SINGLE_STEP_EN
            step_q   <= 1'b0;
            single_q <= 1'b0;
`endif
        end else begin
            cs_q <= 1'b0;
`ifdef CLKGEN_SINGLE_STEP_EN
            step_q <= step;
`endif
            case (state_q)
                S_IDLE: begin
                    if (start_idle_d) begin
                        state_q  <= S_PH1;
                        cnt_q    <= PH1_LD;
                        ph1_q    <= 1'b1;
                        ph1b_q   <= 1'b0;
                        cs_q     <= 1'b1;
                        run_q    <= 1'b1;
`ifdef CLKGEN_SINGLE_STEP_EN
                        single_q <= step_mode;
`endif
                    end
                end
                S_PH1: begin
                    if (cnt_zero) begin
                        state_q <= S_GAP1;
                        cnt_q   <= GAP_LD;
                        ph1_q   <= 1'b0;
                        ph1b_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP1: begin
                    if (cnt_zero) begin
                        state_q <= S_PH2;
                        cnt_q   <= PH2_LD;
                        ph2_q   <= 1'b1;
                        ph2b_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_PH2: begin
                    if (cnt_zero) begin
                        state_q <= S_GAP2;
                        cnt_q   <= GAP_LD;
                        ph2_q   <= 1'b0;
                        ph2b_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP2: begin
                    // en is only honoured here, so a dropped en never cuts a phase short.
                    if (cnt_zero) begin
                        if (start_again_d) begin
                            state_q <= S_PH1;
                            cnt_q   <= PH1_LD;
                            ph1_q   <= 1'b1;
                            ph1b_q  <= 1'b0;
                            cs_q    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            cnt_q   <= '0;
                            run_q   <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    ph1_q   <= 1'b0;
                    ph1b_q  <= 1'b1;
                    ph2_q   <= 1'b0;
                    ph2b_q  <= 1'b1;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ph1         = ph1_q;
    assign ph1b        = ph1b_q;
    assign ph2         = ph2_q;
    assign ph2b        = ph2b_q;
    assign cycle_start = cs_q;
    assign running     = run_q;

endmodule

// File: tb/tb_two_phase_clkgen.sv
// Scoreboard bench for two_phase_clkgen: default instance plus a (3,1,2) instance.
module tb_two_phase_clkgen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0, en = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic ph1, ph1b, ph2, ph2b, cycle_start, running;

    logic rst4_n = 1'b0, en4 = 1'b0, step_mode4 = 1'b0, step4 = 1'b0;
    logic d4_ph1, d4_ph1b, d4_ph2, d4_ph2b, d4_cs, d4_running;

    two_phase_clkgen u_dut (
        .clk(clk), .reset_n(reset_n), .en(en),
`ifdef CLKGEN_SINGLE_STEP_EN
        .step_mode(step_mode), .step(step),
`endif
        .ph1(ph1), .ph1b(ph1b), .ph2(ph2), .ph2b(ph2b),
        .cycle_start(cycle_start), .running(running)
    );

    two_phase_clkgen #(.PH1_CYC(3), .PH2_CYC(1), .GAP_CYC(2), .CNT_W(4)) u_d4 (
        .clk(clk), .reset_n(rst4_n), .en(en4),
`ifdef CLKGEN_SINGLE_STEP_EN
        .step_mode(step_mode4), .step(step4),
`endif
        .ph1(d4_ph1), .ph1b(d4_ph1b), .ph2(d4_ph2), .ph2b(d4_ph2b),
        .cycle_start(d4_cs), .running(d4_running)
    );

    typedef struct packed {
        logic ph1;
        logic ph2;
        logic cs;
        logic run;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic act, input logic exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp_v);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    // Pattern characters: '1' ph1 high, '2' ph2 high, '0' gap while running, 'i' idle.
    function automatic exp_t mk(input byte c, input logic cs);
        exp_t r;
        r.ph1 = (c == "1");
        r.ph2 = (c == "2");
        r.cs  = cs;
        r.run = (c != "i");
        return r;
    endfunction

    task automatic drv(input logic r, input logic e, input logic s, input byte c, input logic cs);
        @(negedge clk);
        reset_n = r;
        en      = e;
        step    = s;
        q.push_back(mk(c, cs));
    endtask

    task automatic drv4(input logic r, input logic e, input byte c, input logic cs);
        @(negedge clk);
        rst4_n = r;
        en4    = e;
        q4.push_back(mk(c, cs));
    endtask

    task automatic stim_main();
        string pat = "110220";
        repeat (5)  drv(1'b0, 1'b0, 1'b0, "i", 1'b0);
        repeat (10) drv(1'b1, 1'b0, 1'b0, "i", 1'b0);
        // Three periods; en drops during ph2 of the third one.
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 6; k++)
                drv(1'b1, !(c == 2 && k >= 4), 1'b0, pat[k], k == 0);
        repeat (4) drv(1'b1, 1'b0, 1'b0, "i", 1'b0);
        // Reset pulse in the middle of PH1.
        drv(1'b1, 1'b1, 1'b0, pat[0], 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_rst_ph1", ph1, 1'b0);
        chk("async_rst_ph1b", ph1b, 1'b1);
        chk("async_rst_ph2b", ph2b, 1'b1);
        chk("async_rst_cs", cycle_start, 1'b0);
        chk("async_rst_running", running, 1'b0);
        q.push_back(mk("i", 1'b0));
        for (int k = 0; k < 6; k++)
            drv(1'b1, k < 4, 1'b0, pat[k], k == 0);
        repeat (3) drv(1'b1, 1'b0, 1'b0, "i", 1'b0);
`ifdef CLKGEN_SINGLE_STEP_EN
        step_mode = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 6; k++)
                drv(1'b1, 1'b1, k == 0, pat[k], k == 0);
            repeat (2) drv(1'b1, 1'b1, 1'b0, "i", 1'b0);
        end
`endif
    endtask

    task automatic stim_d4();
        string p4 = "11100200";
        repeat (3) drv4(1'b0, 1'b0, "i", 1'b0);
        repeat (2) drv4(1'b1, 1'b0, "i", 1'b0);
        for (int p = 0; p < 125; p++)
            for (int k = 0; k < 8; k++)
                drv4(1'b1, !(p == 124 && k >= 1), p4[k], k == 0);
        repeat (2) drv4(1'b1, 1'b0, "i", 1'b0);
    endtask

    initial begin : mon_main
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("overlap", ph1 & ph2, 1'b0);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ph1", ph1, e.ph1);
                chk("ph1b", ph1b, ~e.ph1);
                chk("ph2", ph2, e.ph2);
                chk("ph2b", ph2b, ~e.ph2);
                chk("cycle_start", cycle_start, e.cs);
                chk("running", running, e.run);
            end
        end
    end

    initial begin : mon_d4
        exp_t e;
        int gap;
        int last;
        int cur;
        gap  = 0;
        last = 0;
        forever begin
            @(posedge clk);
            #1;
            chk("d4_overlap", d4_ph1 & d4_ph2, 1'b0);
            if (!d4_running) begin
                gap  = 0;
                last = 0;
            end else if (d4_ph1 || d4_ph2) begin
                cur = d4_ph1 ? 1 : 2;
                if (last != 0 && cur != last) chk("d4_gap_ge2", gap >= 2, 1'b1);
                gap  = 0;
                last = cur;
            end else begin
                gap++;
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                chk("d4_ph1", d4_ph1, e.ph1);
                chk("d4_ph1b", d4_ph1b, ~e.ph1);
                chk("d4_ph2", d4_ph2, e.ph2);
                chk("d4_ph2b", d4_ph2b, ~e.ph2);
                chk("d4_cycle_start", d4_cs, e.cs);
                chk("d4_running", d4_running, e.run);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: run did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        fork
            stim_main();
            stim_d4();
        join
        repeat (3) @(negedge clk);
        chk_int("sb_drain", q.size(), 0);
        chk_int("sb4_drain", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
